// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. Runs on the free-running board clock and retries on lock timeout.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 25000,
  parameter int STABLE_CYCLES       = 2500,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             rst_out_n,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count,
  output logic [1:0]       state_dbg
);

  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_PLLRST    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic                   pll_rst_q, pll_rst_d;
  logic                   run_q, run_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic [CNT_W-1:0]       retry_q, retry_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      run_q     <= run_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  // A relock request always restarts a full-width PLL reset pulse, even from S_PLLRST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    if (relock_req) begin
      state_d = S_PLLRST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_PLLRST: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_PLLRST;
            cnt_d   = '0;
            retry_d = sat_inc(retry_q);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            loss_d  = sat_inc(loss_q);
          end
        end
        default: begin
          state_d = S_PLLRST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from next state so they switch on the same edge as the state
  always_comb begin
    pll_rst_d = (state_d == S_PLLRST);
    run_d     = (state_d == S_RUN);
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out_n   = run_q;
  assign ready       = run_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table for power-up/relock, hand sequences for
// timeouts, chatter, lock loss and async reset, then random stimulus against a model.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int PULSE = 4;
  localparam int TMO = 20;
  localparam int STAB = 10;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst, rst_out_n, ready;
  logic [CW-1:0] loss_count, retry_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .RST_PULSE_CYCLES(PULSE), .LOCK_TIMEOUT_CYCLES(TMO),
    .STABLE_CYCLES(STAB), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .locked(locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .rst_out_n(rst_out_n), .ready(ready),
    .loss_count(loss_count), .retry_count(retry_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, time spent in phase, event totals, lock history.
  int m_phase, m_elapsed, m_loss, m_retry;
  bit m_hist[SYNC];

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_loss = 0; m_retry = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
  endtask

  task automatic model_step(input bit lk, input bit rq);
    bit ls;
    int nphase;
    ls = m_hist[SYNC-1];
    nphase = m_phase;
    if (rq) nphase = 0;
    else if (m_phase == 0) begin
      if (m_elapsed + 1 >= PULSE) nphase = 1;
    end else if (m_phase == 1) begin
      if (ls) nphase = 2;
      else if (m_elapsed + 1 >= TMO) begin
        nphase = 0;
        m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
      end
    end else if (m_phase == 2) begin
      if (!ls) nphase = 1;
      else if (m_elapsed + 1 >= STAB) nphase = 3;
    end else begin
      if (!ls) begin
        nphase = 1;
        m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
      end
    end
    m_elapsed = (rq || nphase != m_phase) ? 0 : m_elapsed + 1;
    m_phase = nphase;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step(locked, relock_req);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int st, input int pll, input int rn,
                            input int rt, input int ls);
    check({name, ".state"}, state_dbg, st);
    check({name, ".pll_rst"}, pll_rst, pll);
    check({name, ".rst_out_n"}, rst_out_n, rn);
    check({name, ".ready"}, ready, rn);
    check({name, ".retry"}, retry_count, rt);
    check({name, ".loss"}, loss_count, ls);
  endtask

  task automatic wait_state(input int st, input string name);
    int n;
    n = 0;
    while (state_dbg != st && n < 200) begin
      tick();
      n++;
    end
    check(name, state_dbg, st);
  endtask

  typedef struct {
    int ncyc; bit lk; bit rq;
    int st; int pll; int rn; int rt; int ls;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rstn_hi, pll_hi, mode, exp_v, act_v;

    // Power-up to RUN, then relock from RUN back to RUN (edge numbers in comments)
    vecs.push_back('{0, 1'b0, 1'b0, 0, 1, 0, 0, 0});  // edge 0
    vecs.push_back('{3, 1'b0, 1'b0, 0, 1, 0, 0, 0});  // edge 3
    vecs.push_back('{1, 1'b0, 1'b0, 1, 0, 0, 0, 0});  // edge 4
    vecs.push_back('{3, 1'b0, 1'b0, 1, 0, 0, 0, 0});  // edge 7
    vecs.push_back('{1, 1'b1, 1'b0, 1, 0, 0, 0, 0});  // edge 8: locked captured
    vecs.push_back('{1, 1'b1, 1'b0, 1, 0, 0, 0, 0});  // edge 9
    vecs.push_back('{1, 1'b1, 1'b0, 2, 0, 0, 0, 0});  // edge 10
    vecs.push_back('{9, 1'b1, 1'b0, 2, 0, 0, 0, 0});  // edge 19
    vecs.push_back('{1, 1'b1, 1'b0, 3, 0, 1, 0, 0});  // edge 20
    vecs.push_back('{5, 1'b1, 1'b0, 3, 0, 1, 0, 0});  // edge 25
    vecs.push_back('{1, 1'b1, 1'b1, 0, 1, 0, 0, 0});  // edge 26: relock
    vecs.push_back('{3, 1'b1, 1'b0, 0, 1, 0, 0, 0});  // edge 29
    vecs.push_back('{1, 1'b1, 1'b0, 1, 0, 0, 0, 0});  // edge 30
    vecs.push_back('{1, 1'b1, 1'b0, 2, 0, 0, 0, 0});  // edge 31
    vecs.push_back('{9, 1'b1, 1'b0, 2, 0, 0, 0, 0});  // edge 40
    vecs.push_back('{1, 1'b1, 1'b0, 3, 0, 1, 0, 0});  // edge 41

    model_reset();
    resetn = 1'b0;
    repeat (2) tick();
    check_outs("reset", 0, 1, 0, 0, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      locked = vecs[i].lk;
      relock_req = vecs[i].rq;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        tick();
        relock_req = 1'b0;
      end
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].pll, vecs[i].rn,
                 vecs[i].rt, vecs[i].ls);
    end

    // Lock never arrives: retry every PULSE+TMO cycles, saturating retry_count
    #2 resetn = 1'b0;
    locked = 1'b0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
    rstn_hi = 0;
    for (int k = 1; k <= 17; k++) begin
      repeat (PULSE + TMO - 1) begin
        tick();
        if (rst_out_n) rstn_hi++;
      end
      check($sformatf("nolock%0d.wait_state", k), state_dbg, 1);
      check($sformatf("nolock%0d.pll_low", k), pll_rst, 0);
      tick();
      check($sformatf("nolock%0d.pll_high", k), pll_rst, 1);
      check($sformatf("nolock%0d.retry", k), retry_count, (k < CMAX) ? k : CMAX);
    end
    check("nolock.rst_out_n_high_cycles", rstn_hi, 0);

    // Chatter: lock_s low for one cycle at stable count 7
    locked = 1'b1;
    wait_state(2, "chatter.enter_stable");
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    check("chatter.still_stable", state_dbg, 2);
    tick();
    check("chatter.back_to_wait", state_dbg, 1);
    tick();
    check("chatter.restable", state_dbg, 2);
    repeat (9) tick();
    check("chatter.rstn_early", rst_out_n, 0);
    tick();
    check("chatter.rstn_rise", rst_out_n, 1);
    check("chatter.state_run", state_dbg, 3);

    // Lock loss in RUN, then relock without a PLL reset pulse
    locked = 1'b0;
    tick();
    check("loss.rstn_e", rst_out_n, 1);
    tick();
    check("loss.rstn_e1", rst_out_n, 1);
    tick();
    check_outs("loss.e2", 1, 0, 0, CMAX, 1);
    locked = 1'b1;
    pll_hi = 0;
    repeat (12) begin
      tick();
      if (pll_rst) pll_hi++;
    end
    check("loss.rstn_before", rst_out_n, 0);
    tick();
    check("loss.rstn_after", rst_out_n, 1);
    check("loss.no_pll_pulse", pll_hi, 0);

    // relock_req in RUN: 4-cycle PLL pulse, loss count untouched
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check_outs("relock.start", 0, 1, 0, CMAX, 1);
    repeat (3) tick();
    check("relock.pll_last", pll_rst, 1);
    tick();
    check("relock.pll_end", pll_rst, 0);

    // Async reset mid-stable clears everything without a clock edge
    wait_state(2, "areset.enter_stable");
    repeat (3) tick();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_outs("areset", 0, 1, 0, 0, 0);

    // Random stimulus against the model
    tick();
    resetn = 1'b1;
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      if (mode == 0) locked = 1'b0;
      else if (mode == 1) locked = 1'b1;
      else if ($urandom_range(0, 7) == 0) locked = ~locked;
      relock_req = ($urandom_range(0, 63) == 0);
      tick();
      exp_v = {m_phase[1:0], (m_phase == 0), (m_phase == 3), (m_phase == 3),
               m_retry[CW-1:0], m_loss[CW-1:0]};
      act_v = {state_dbg, pll_rst, rst_out_n, ready, retry_count, loss_count};
      check($sformatf("rand%0d", c), act_v, exp_v);
    end
    relock_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
